// File: rtl/trace_pkg.sv
// Shared types for the round trace buffer: entry layout, FSM states, drop counter ceiling.
// Entry field widths track the datapath rule count and round counter width.
`ifndef RULES
`define RULES 16
`endif

package trace_pkg;

    localparam int TRACE_WIDTH = `RULES;
    localparam int TRACE_RND_W = 10;
    localparam int DROP_MAX    = 255;

    typedef struct packed {
        logic [TRACE_WIDTH-1:0] state;
        logic [TRACE_RND_W-1:0] round;
        logic                   last;
    } trace_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DRAIN
    } trace_state_e;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO of trace entries; head visible the cycle after push.
// Push is refused only when full with no simultaneous pop; flush empties it in one cycle.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  trace_entry_t             din,
    output trace_entry_t             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    trace_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the read side is qualified by count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/round_trace_buffer.sv
// Records one datapath snapshot per completed round into a FIFO drained by the host (valid/ready).
// Capture-to-head latency 1; the last FIFO slot is held back so the steady-state entry is never dropped.
module round_trace_buffer
    import trace_pkg::*;
#(
    parameter int WIDTH = `RULES,
    parameter int RND_W = 10,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [WIDTH-1:0] network_state,
    input  logic [RND_W-1:0] round_number,
    input  logic             steady_state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_state,
    output logic [RND_W-1:0] out_round,
    output logic             out_last,
    output logic             overflow,
    output logic [7:0]       drop_count,
    output logic             busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    trace_state_e     state;
    trace_state_e     state_nxt;
    logic [RND_W-1:0] prev_round;
    logic             prev_ss;

    trace_entry_t     wr_entry;
    trace_entry_t     head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    logic             capture;
    logic             has_room;
    logic             drop;

    assign wr_entry.state = network_state;
    assign wr_entry.round = round_number;
    assign wr_entry.last  = steady_state;

    // A round change and a steady-state rise in the same cycle are a single event.
    assign capture    = (state == ARMED) &&
                        ((round_number != prev_round) || (!prev_ss && steady_state));
    assign has_room   = !fifo_full && (fifo_count < CW'(DEPTH - 1));
    assign fifo_push  = capture && (steady_state || has_room);
    assign drop       = capture && !fifo_push;
    assign fifo_pop   = out_valid && out_ready;
    assign fifo_flush = (state == IDLE) && arm;

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (wr_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arm) state_nxt = ARMED;
            ARMED:   if (fifo_push && steady_state) state_nxt = DRAIN;
            DRAIN:   if (fifo_pop && head.last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            prev_round <= '0;
            prev_ss    <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && arm) begin
                prev_round <= round_number;
                prev_ss    <= steady_state;
                overflow   <= 1'b0;
                drop_count <= '0;
            end else if (state == ARMED) begin
                prev_round <= round_number;
                prev_ss    <= steady_state;
                if (drop) begin
                    overflow <= 1'b1;
                    if (drop_count != 8'(DROP_MAX)) drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

    // Head fields read as zero when nothing is queued.
    assign out_valid = !fifo_empty;
    assign out_state = out_valid ? head.state : '0;
    assign out_round = out_valid ? head.round : '0;
    assign out_last  = out_valid && head.last;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_round_trace_buffer.sv
// Randomized bench for round_trace_buffer against a queue-based reference of the trace rules.
`ifndef RULES
`define RULES 16
`endif

module tb_round_trace_buffer;

    localparam int W     = `RULES;
    localparam int RW    = 10;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic [W-1:0]  network_state = '0;
    logic [RW-1:0] round_number = '0;
    logic          steady_state = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [W-1:0]  out_state;
    logic [RW-1:0] out_round;
    logic          out_last;
    logic          overflow;
    logic [7:0]    drop_count;
    logic          busy;

    round_trace_buffer #(
        .RND_W (RW),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arm           (arm),
        .network_state (network_state),
        .round_number  (round_number),
        .steady_state  (steady_state),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_state     (out_state),
        .out_round     (out_round),
        .out_last      (out_last),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  st;
        logic [RW-1:0] rnd;
        logic          last;
    } ent_t;

    // Reference model: 0 = idle, 1 = capturing, 2 = draining
    ent_t          mq[$];
    int            m_mode;
    logic [RW-1:0] m_prev;
    logic          m_pss;
    logic          m_ovf;
    int            m_drops;

    ent_t          popped[$];
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode  = 0;
        m_prev  = '0;
        m_pss   = 1'b0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic model_step();
        int   occ = mq.size();
        bit   pop = (occ > 0) && out_ready;
        bit   do_push = 0;
        ent_t e;
        case (m_mode)
            0: if (arm) begin
                mq.delete();
                m_ovf   = 1'b0;
                m_drops = 0;
                m_prev  = round_number;
                m_pss   = steady_state;
                m_mode  = 1;
            end
            1: begin
                if (round_number != m_prev || (!m_pss && steady_state)) begin
                    if (steady_state || occ < DEPTH - 1) begin
                        do_push = 1;
                        e = '{network_state, round_number, steady_state};
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drops < 255) m_drops++;
                    end
                end
                m_prev = round_number;
                m_pss  = steady_state;
            end
            default: if (pop && mq[0].last) m_mode = 0;
        endcase
        if (pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back(e);
            if (e.last) m_mode = 2;
        end
    endtask

    task automatic compare();
        check("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("out_state", out_state, mq[0].st);
            check("out_round", out_round, mq[0].rnd);
            check("out_last", out_last, mq[0].last);
        end else begin
            check("out_state_empty", out_state, 0);
            check("out_round_empty", out_round, 0);
            check("out_last_empty", out_last, 0);
        end
        check("overflow", overflow, m_ovf);
        check("drop_count", drop_count, m_drops);
        check("busy", busy, m_mode != 0);
    endtask

    task automatic step();
        network_state = W'($urandom);
        if (out_valid && out_ready) popped.push_back('{out_state, out_round, out_last});
        if (rst) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic drain(input bit rnd_ready);
        for (int i = 0; i < 300 && busy; i++) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
        check("drained_idle", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        model_reset();
        @(posedge clk);
        #1;
        compare();
        rst = 1'b0;
        step();

        // Basic trace
        popped.delete();
        round_number = 0; steady_state = 0; out_ready = 1;
        pulse_arm();
        round_number = 1; step();
        round_number = 2; step();
        round_number = 3; steady_state = 1; step();
        drain(0);
        check("basic_count", popped.size(), 3);
        if (popped.size() == 3) begin
            check("basic_r0", popped[0].rnd, 1);
            check("basic_r1", popped[1].rnd, 2);
            check("basic_r2", popped[2].rnd, 3);
            check("basic_l1", popped[1].last, 0);
            check("basic_l2", popped[2].last, 1);
        end

        // Overflow with host stalled
        popped.delete();
        steady_state = 0; round_number = 5; out_ready = 0;
        pulse_arm();
        for (int i = 0; i < 20; i++) begin
            round_number = round_number + 1'b1;
            step();
        end
        steady_state = 1;
        step();
        step();
        check("ovf_flag", overflow, 1);
        check("ovf_drops", drop_count, 5);
        check("ovf_busy", busy, 1);
        drain(0);
        check("ovf_count", popped.size(), 16);
        if (popped.size() == 16) begin
            check("ovf_r14", popped[14].rnd, 20);
            check("ovf_l14", popped[14].last, 0);
            check("ovf_r15", popped[15].rnd, 25);
            check("ovf_l15", popped[15].last, 1);
        end

        // Simultaneous round change and steady-state rise
        popped.delete();
        steady_state = 0; round_number = 100; out_ready = 0;
        pulse_arm();
        round_number = 101; steady_state = 1; step();
        step();
        step();
        check("simul_busy", busy, 1);
        drain(0);
        check("simul_count", popped.size(), 1);
        if (popped.size() == 1) begin
            check("simul_round", popped[0].rnd, 101);
            check("simul_last", popped[0].last, 1);
        end

        // Round counter wrap
        popped.delete();
        steady_state = 0; round_number = 1022; out_ready = 1;
        pulse_arm();
        round_number = 1023; step();
        round_number = 0; step();
        steady_state = 1; step();
        drain(0);
        check("wrap_count", popped.size(), 3);
        if (popped.size() == 3) begin
            check("wrap_r0", popped[0].rnd, 1023);
            check("wrap_r1", popped[1].rnd, 0);
            check("wrap_l1", popped[1].last, 0);
            check("wrap_l2", popped[2].last, 1);
        end

        // Randomized traces with backpressure and stray arm pulses
        for (int t = 0; t < 25; t++) begin
            steady_state = 0;
            round_number = RW'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            pulse_arm();
            for (int c = 0, len = $urandom_range(5, 40); c < len; c++) begin
                if ($urandom_range(0, 2) == 0) round_number = round_number + 1'b1;
                else if ($urandom_range(0, 9) == 0) round_number = RW'($urandom);
                out_ready = 1'($urandom_range(0, 1));
                arm = ($urandom_range(0, 7) == 0);
                step();
            end
            arm = 0;
            steady_state = 1;
            if ($urandom_range(0, 1) == 1) round_number = round_number + 1'b1;
            step();
            drain(1);
        end

        // Reset while draining
        popped.delete();
        steady_state = 0; round_number = 0; out_ready = 0;
        pulse_arm();
        for (int i = 1; i <= 4; i++) begin
            round_number = RW'(i);
            step();
        end
        round_number = 5; steady_state = 1; step();
        step();
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drops", drop_count, 0);
        step();
        rst = 1'b0;
        steady_state = 0; round_number = 7; out_ready = 1;
        pulse_arm();
        round_number = 8; step();
        steady_state = 1; step();
        drain(0);
        check("post_rst_count", popped.size(), 2);
        if (popped.size() == 2) begin
            check("post_rst_r0", popped[0].rnd, 8);
            check("post_rst_l1", popped[1].last, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/round_trace_buffer.md
# round_trace_buffer

Downstream consumer of the asynchronous-update network datapath: watches `network_state`, `round_number` and `steady_state` during a run and records one snapshot per completed round into an on-chip FIFO. The host drains the FIFO via a valid/ready stream. The final entry, taken when steady state is reached, is tagged `out_last`. Overflow drops intermediate snapshots but never the final one.

## Interface
Parameters:
- `WIDTH`, default `` `RULES ``: snapshot width, matches `network_state`.
- `RND_W`, default 10: round counter width.
- `DEPTH`, default 16: FIFO entries; power of 2, at least 4.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `arm`  in  1  one-cycle pulse that starts a new trace.
- `network_state`  in  WIDTH  masked network state from the datapath.
- `round_number`  in  RND_W  round counter from the datapath FSM.
- `steady_state`  in  1  steady-state flag from the datapath FSM.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  host accepts the head entry.
- `out_state`  out  WIDTH  head snapshot.
- `out_round`  out  RND_W  round number of the head snapshot.
- `out_last`  out  1  head is the final (steady-state) entry.
- `overflow`  out  1  sticky: at least one snapshot dropped this trace.
- `drop_count`  out  8  dropped snapshots, saturating at 255.
- `busy`  out  1  high in ARMED or DRAIN.

## Operation
- States: IDLE, ARMED, DRAIN.
- **IDLE:** inputs ignored. `arm` does all of the following, then enters ARMED:
  - flushes the FIFO;
  - clears `overflow` and `drop_count`;
  - loads `prev_round <= round_number`;
  - loads `prev_ss <= steady_state`.
- **ARMED, capture event:** fires when `round_number != prev_round` or when `steady_state` rises (`prev_ss == 0`, `steady_state == 1`).
  - One event produces one entry, even if both conditions hold in the same cycle.
  - Entry is {`network_state`, `round_number`, last = `steady_state`}.
  - `prev_round` and `prev_ss` update every ARMED cycle.
  - A `round_number` wrap (1023→0) counts as a change and is captured.
- **Space reservation:** a non-last entry is pushed only if occupancy is below DEPTH−1.
  - Otherwise it is dropped: `overflow` is set and `drop_count` increments, saturating.
  - A last entry is always pushed, because the final slot is reserved for it.
- After pushing a last entry, the block enters DRAIN.
- **DRAIN:** no captures. When the last entry is popped, the block enters IDLE.
- `arm` in ARMED or DRAIN is ignored.
- **Pop:** `out_valid && out_ready`. A push and a pop in the same cycle leave occupancy unchanged and are legal at any occupancy.
- `out_*` hold stable while `out_valid && !out_ready`.
- `busy = (state != IDLE)`.

## Timing
- Reset values:
  - state IDLE, FIFO empty;
  - `out_valid`, `out_last`, `overflow`, `busy` = 0;
  - `out_state`, `out_round`, `drop_count` = 0.
- `rst` asserted mid-trace clears everything immediately (asynchronous). Stored entries are lost.
- `arm` sampled in cycle N: `busy` = 1 in N+1. Capture events are evaluated from N+1 onward.
- Capture event in cycle N with the FIFO empty: `out_valid` = 1 and `out_*` show the entry in N+1 (latency 1, first-word fall-through).
- Pop in cycle N: the next entry appears in N+1, or `out_valid` = 0 if the FIFO is empty.
- Last entry popped in cycle N: `busy` = 0 in N+1. A new `arm` is accepted from N+1.
- `overflow` and `drop_count` update in the cycle after the dropped event. They hold their values through DRAIN and IDLE until the next `arm`.

## Structure
- Package `trace_pkg` holds:
  - `trace_entry_t`, a packed struct {state[WIDTH], round[RND_W], last};
  - `trace_state_e`, the enum {IDLE, ARMED, DRAIN};
  - constant `DROP_MAX` = 255.
- Sub-module `trace_fifo`: synchronous first-word-fall-through FIFO of `trace_entry_t`, parameterized by DEPTH.
  - Ports: push, pop, flush, full, empty, count.
  - Reset asynchronous, active-high.
- Top level contains the FSM, edge/change detection, reservation check and drop counters.

## Test plan
- **Basic trace:** `arm`, then `round_number` 0→1→2→3 with `steady_state` rising at round 3, `out_ready` = 1.
  - Expect 3 entries, rounds 1, 2 and 3, with `out_last` = 1 only on round 3.
  - `busy` falls one cycle after the round-3 pop.
- **Overflow, DEPTH = 16, `out_ready` = 0:** 20 round changes, then steady.
  - 15 entries stored, 5 dropped.
  - `overflow` = 1, `drop_count` = 5.
  - Last entry stored in slot 16 and popped last.
- **Simultaneous events:** round change and `steady_state` rise in the same cycle.
  - Exactly one entry, with last = 1.
  - FSM enters DRAIN.
- **Wrap:** `round_number` steps 1022→1023→0.
  - Entries with rounds 1023 and 0.
- **Backpressure:** toggle `out_ready` randomly during capture.
  - Entries arrive in order with no duplicates.
  - `out_*` stable while stalled.
- **Reset mid-DRAIN:** `rst` pulse with 5 entries queued.
  - Next cycle: `out_valid` = 0, `busy` = 0, `drop_count` = 0.
  - A fresh `arm` then works normally.
